// File: rtl/cp0_timer_ext.sv
// Coprocessor-0 beside the M stage: SR/Cause/EPC/PRId/BadVAddr/Count/Compare,
// exception/interrupt entry, ERET exit and a Count/Compare timer interrupt.
module cp0_timer_ext #(
  parameter int          NUM_HWINT  = 6,
  parameter int          TIMER_LINE = 5,
  parameter int          COUNT_DIV  = 2,
  parameter logic [31:0] SR_INIT    = 32'h0000_FF11,
  parameter logic [31:0] PRID_VAL   = 32'h0001_0001
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4:0]           addr,
  input  logic                 we,
  input  logic [31:0]          wd,
  input  logic [31:0]          pc_m,
  input  logic                 exc_bd_m,
  input  logic [4:0]           exc_code_m,
  input  logic [31:0]          bad_vaddr_m,
  input  logic                 eret,
  input  logic [NUM_HWINT-1:0] hw_int,
  output logic                 exc_handle,
  output logic [31:0]          epc,
  output logic [31:0]          data_out,
  output logic                 timer_irq
);

  localparam int          PW         = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(COUNT_DIV - 1);
  // IM bits beyond NUM_HWINT are forced to zero on every SR load
  localparam logic [31:0] SR_MASK    =
    ~(((32'h1 << (6 - NUM_HWINT)) - 32'h1) << (10 + NUM_HWINT));

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_SR       = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [4:0] REG_PRID     = 5'd15;

  logic [31:0]          sr_q, sr_d, epc_q, epc_d, badva_q, badva_d;
  logic [31:0]          count_q, count_d, compare_q, compare_d, prid_q, prid_d;
  logic                 bd_q, bd_d, ti_q, ti_d;
  logic [4:0]           exc_code_q, exc_code_d;
  logic [1:0]           sw_ip_q, sw_ip_d;
  logic [PW-1:0]        presc_q, presc_d;
  logic [NUM_HWINT-1:0] ip_q, ip_vec, ti_vec, im;
  logic                 int_req, exc_req, tick;
  logic [31:0]          count_inc, cause_rd;

  always_comb begin
    ti_vec             = '0;
    ti_vec[TIMER_LINE] = ti_q;
  end

  assign ip_vec     = hw_int | ti_vec;
  assign im         = sr_q[10 +: NUM_HWINT];
  assign int_req    = sr_q[0] & ~sr_q[1] & (|(ip_vec & im));
  assign exc_req    = ~sr_q[1] & (exc_code_m != 5'd0);
  assign exc_handle = int_req | exc_req;
  assign tick       = (presc_q == PRESC_LAST);
  assign count_inc  = count_q + 32'd1;

  always_comb begin
    // NOTE: every next-state signal gets its hold value first, so no path leaves it unassigned and no latch is inferred.
    sr_d       = sr_q;
    epc_d      = epc_q;
    badva_d    = badva_q;
    count_d    = count_q;
    compare_d  = compare_q;
    prid_d     = prid_q;
    bd_d       = bd_q;
    ti_d       = ti_q;
    exc_code_d = exc_code_q;
    sw_ip_d    = sw_ip_q;
    presc_d    = tick ? '0 : presc_q + PW'(1);

    if (tick) begin
      count_d = count_inc;
      if (count_inc == compare_q) ti_d = 1'b1;
    end

    // Entry beats ERET beats mtc0; a losing mtc0 is simply dropped
    if (exc_handle) begin
      sr_d[1]    = 1'b1;
      bd_d       = exc_bd_m;
      exc_code_d = int_req ? 5'd0 : exc_code_m;
      epc_d      = exc_bd_m ? pc_m - 32'd4 : pc_m;
      if (!int_req && (exc_code_m == 5'd4 || exc_code_m == 5'd5)) badva_d = bad_vaddr_m;
    end else if (eret) begin
      sr_d[1] = 1'b0;
    end else if (we) begin
      case (addr)
        REG_COUNT:   begin count_d = wd; presc_d = '0; end
        REG_COMPARE: begin compare_d = wd; ti_d = 1'b0; end
        REG_SR:      sr_d = wd & SR_MASK;
        REG_CAUSE:   sw_ip_d = wd[9:8];
        REG_EPC:     epc_d = wd;
        REG_PRID:    prid_d = wd;
        default:     ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      sr_q       <= SR_INIT & SR_MASK;
      epc_q      <= '0;
      badva_q    <= '0;
      count_q    <= '0;
      compare_q  <= 32'hFFFF_FFFF;
      prid_q     <= PRID_VAL;
      bd_q       <= 1'b0;
      ti_q       <= 1'b0;
      exc_code_q <= '0;
      sw_ip_q    <= '0;
      presc_q    <= '0;
      ip_q       <= '0;
    end else begin
      sr_q       <= sr_d;
      epc_q      <= epc_d;
      badva_q    <= badva_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      prid_q     <= prid_d;
      bd_q       <= bd_d;
      ti_q       <= ti_d;
      exc_code_q <= exc_code_d;
      sw_ip_q    <= sw_ip_d;
      presc_q    <= presc_d;
      ip_q       <= ip_vec;
    end
  end

  always_comb begin
    cause_rd                  = '0;
    cause_rd[31]              = bd_q;
    cause_rd[30]              = ti_q;
    cause_rd[10 +: NUM_HWINT] = ip_q;
    cause_rd[9:8]             = sw_ip_q;
    cause_rd[6:2]             = exc_code_q;
  end

  always_comb begin
    case (addr)
      REG_BADVADDR: data_out = badva_q;
      REG_COUNT:    data_out = count_q;
      REG_COMPARE:  data_out = compare_q;
      REG_SR:       data_out = sr_q;
      REG_CAUSE:    data_out = cause_rd;
      REG_EPC:      data_out = epc_q;
      REG_PRID:     data_out = prid_q;
      default:      data_out = '0;
    endcase
  end

  assign epc       = epc_q;
  assign timer_irq = ti_q;

endmodule

// File: tb/tb_cp0_timer_ext.sv
// Directed bench for cp0_timer_ext: stimulus queues expected outputs per cycle,
// a negedge monitor pops and compares them against the DUT.
module tb_cp0_timer_ext;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  addr;
  logic        we;
  logic [31:0] wd;
  logic [31:0] pc_m;
  logic        exc_bd_m;
  logic [4:0]  exc_code_m;
  logic [31:0] bad_vaddr_m;
  logic        eret;
  logic [5:0]  hw_int;
  logic        exc_handle;
  logic [31:0] epc;
  logic [31:0] data_out;
  logic        timer_irq;

  cp0_timer_ext dut (
    .clk(clk), .reset(reset), .addr(addr), .we(we), .wd(wd), .pc_m(pc_m),
    .exc_bd_m(exc_bd_m), .exc_code_m(exc_code_m), .bad_vaddr_m(bad_vaddr_m),
    .eret(eret), .hw_int(hw_int), .exc_handle(exc_handle), .epc(epc),
    .data_out(data_out), .timer_irq(timer_irq)
  );

  always #5 clk = ~clk;

  typedef enum int { SEL_DATA, SEL_EXC, SEL_EPC, SEL_TIRQ } sel_e;
  typedef struct {
    string       name;
    sel_e        sel;
    logic [31:0] exp;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      case (e.sel)
        SEL_DATA: act = data_out;
        SEL_EXC:  act = {31'b0, exc_handle};
        SEL_EPC:  act = epc;
        default:  act = {31'b0, timer_irq};
      endcase
      vectors++;
      if (act !== e.exp) begin
        miscompares++;
        $display("FAIL %s: got %h expected %h (cycle %0d)", e.name, act, e.exp, cyc);
      end
    end
  end

  task automatic check(input string name, input sel_e sel, input logic [31:0] exp);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = exp;
    e.cyc  = cyc;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    addr = a;
    we   = 1'b1;
    wd   = d;
    step();
    we   = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string name);
    addr = a;
    check(name, SEL_DATA, exp);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] reset_vals [8] = '{32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF,
                                    32'h0000_FF11, 32'h0, 32'h0, 32'h0001_0001};
    reset = 1'b1; addr = '0; we = 1'b0; wd = '0; pc_m = '0; exc_bd_m = 1'b0;
    exc_code_m = '0; bad_vaddr_m = '0; eret = 1'b0; hw_int = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // 1: reset values
    check("rst_exc_handle", SEL_EXC, 32'd0);
    check("rst_epc", SEL_EPC, 32'd0);
    check("rst_timer_irq", SEL_TIRQ, 32'd0);
    for (int i = 0; i < 8; i++) rd(5'(8 + i), reset_vals[i], $sformatf("rst_reg%0d", 8 + i));

    // 2: hardware interrupt entry, no re-entry under EXL, ERET re-entry
    mtc0(5'd12, 32'h0000_0401);
    pc_m   = 32'h0000_1000;
    hw_int = 6'b000001;
    check("int_entry", SEL_EXC, 32'd1);
    step();
    check("int_no_reentry", SEL_EXC, 32'd0);
    rd(5'd13, 32'h0000_0400, "int_cause");
    rd(5'd14, 32'h0000_1000, "int_epc");
    rd(5'd12, 32'h0000_0403, "int_sr_exl");
    eret = 1'b1;
    check("eret_cycle_exc", SEL_EXC, 32'd0);
    step();
    eret = 1'b0;
    check("eret_reentry", SEL_EXC, 32'd1);
    rd(5'd12, 32'h0000_0401, "eret_sr");
    hw_int = '0;
    mtc0(5'd12, 32'h0);

    // 3: address error in delay slot
    exc_code_m = 5'd4; exc_bd_m = 1'b1; pc_m = 32'h0000_3008; bad_vaddr_m = 32'h0000_1233;
    check("adel_entry", SEL_EXC, 32'd1);
    step();
    exc_code_m = 5'd8; exc_bd_m = 1'b0; bad_vaddr_m = '0;
    check("exl_blocks_exc", SEL_EXC, 32'd0);
    check("adel_epc_out", SEL_EPC, 32'h0000_3004);
    rd(5'd14, 32'h0000_3004, "adel_epc");
    exc_code_m = 5'd0;
    rd(5'd8, 32'h0000_1233, "adel_badvaddr");
    rd(5'd13, 32'h8000_0010, "adel_cause");
    mtc0(5'd12, 32'h0);

    // 4: Count/Compare timer interrupt
    mtc0(5'd11, 32'd5);
    mtc0(5'd9, 32'd0);
    repeat (9) step();
    check("ti_before", SEL_TIRQ, 32'd0);
    step();
    check("ti_set", SEL_TIRQ, 32'd1);
    check("ti_masked_ie0", SEL_EXC, 32'd0);
    rd(5'd9, 32'd5, "ti_count");
    pc_m = 32'h0000_4000;
    mtc0(5'd12, 32'h0000_8001);
    check("timer_int_entry", SEL_EXC, 32'd1);
    rd(5'd13, 32'hC000_8010, "timer_cause_pre");
    rd(5'd13, 32'h4000_8000, "timer_cause_post");
    rd(5'd14, 32'h0000_4000, "timer_epc");
    mtc0(5'd11, 32'h0000_1000);
    check("ti_cleared", SEL_TIRQ, 32'd0);
    mtc0(5'd12, 32'h0);

    // 5: write priority
    pc_m = 32'h0000_5000; exc_code_m = 5'd8;
    addr = 5'd14; we = 1'b1; wd = 32'h0000_DEAD;
    check("sys_entry", SEL_EXC, 32'd1);
    step();
    we = 1'b0; exc_code_m = 5'd0;
    rd(5'd14, 32'h0000_5000, "sys_epc_wins");
    rd(5'd13, 32'h0000_0020, "sys_cause");
    mtc0(5'd12, 32'h0);
    mtc0(5'd14, 32'h0000_DEAD);
    rd(5'd14, 32'h0000_DEAD, "epc_write");
    eret = 1'b1;
    mtc0(5'd14, 32'h0000_BEEF);
    eret = 1'b0;
    rd(5'd14, 32'h0000_DEAD, "eret_drops_mtc0");
    mtc0(5'd9, 32'h0000_0100);
    step();
    mtc0(5'd9, 32'h0000_0200);
    rd(5'd9, 32'h0000_0200, "count_write_wins");
    rd(5'd9, 32'h0000_0200, "count_presc_hold");
    rd(5'd9, 32'h0000_0201, "count_presc_wrap");

    // 6: Count wrap sets TI, then reset with EXL=1
    mtc0(5'd11, 32'h0);
    mtc0(5'd9, 32'hFFFF_FFFF);
    step();
    check("wrap_ti_before", SEL_TIRQ, 32'd0);
    step();
    check("wrap_ti_set", SEL_TIRQ, 32'd1);
    rd(5'd9, 32'h0, "wrap_count");
    exc_code_m = 5'd8;
    step();
    exc_code_m = 5'd0;
    rd(5'd12, 32'h0000_0002, "pre_reset_exl");
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst2_timer_irq", SEL_TIRQ, 32'd0);
    check("rst2_epc", SEL_EPC, 32'd0);
    check("rst2_exc_handle", SEL_EXC, 32'd0);
    rd(5'd9, 32'h0, "rst2_count");
    rd(5'd12, 32'h0000_FF11, "rst2_sr");
    rd(5'd13, 32'h0, "rst2_cause");
    rd(5'd11, 32'hFFFF_FFFF, "rst2_compare");

    step();
    step();
    if (sb.size() != 0) begin
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      vectors     += sb.size();
      miscompares += sb.size();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
